// File: rtl/sample_pair_if.sv
// sample_pair_if: stream-in / pair-out handshake bundle for sample_pair_collector
//   in_valid/in_ready/in_data/flush  : sample stream from the producer
//   pair_valid/pair_ready            : pair handshake to the consumer
//   pair_a/pair_b/pair_odd           : zero-extended pair and flush-formed flag
//   pair_count                       : pairs handed off since reset
//   modport slave  : collector view
//   modport master : producer/consumer (testbench) view
interface sample_pair_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              pair_valid;
    logic              pair_ready;
    logic [DATA_W:0]   pair_a;
    logic [DATA_W:0]   pair_b;
    logic              pair_odd;
    logic [CNT_W-1:0]  pair_count;

    modport slave (
        input  in_valid, in_data, flush, pair_ready,
        output in_ready, pair_valid, pair_a, pair_b, pair_odd, pair_count
    );

    modport master (
        output in_valid, in_data, flush, pair_ready,
        input  in_ready, pair_valid, pair_a, pair_b, pair_odd, pair_count
    );
endinterface

// File: rtl/sample_pair_collector.sv
// sample_pair_collector: groups consecutive stream samples into (a, b) pairs
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low
//   bus   : sample_pair_if slave modport (sample stream in, pair stream out,
//           pair_count statistics)
module sample_pair_collector #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input logic         clk,
    input logic         rst_n,
    sample_pair_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, HAVE_A, FULL} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              odd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_fire;
    logic              out_fire;

    // A consumer draining the held pair frees the slot in the same cycle.
    assign bus.in_ready   = (state_q != FULL) | bus.pair_ready;
    assign bus.pair_valid = state_q == FULL;
    assign bus.pair_a     = {1'b0, a_q};
    assign bus.pair_b     = {1'b0, b_q};
    assign bus.pair_odd   = odd_q;
    assign bus.pair_count = cnt_q;
    assign in_fire        = bus.in_valid & bus.in_ready;
    assign out_fire       = bus.pair_valid & bus.pair_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            odd_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (out_fire) cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                EMPTY: if (in_fire) begin
                    a_q     <= bus.in_data;
                    state_q <= HAVE_A;
                end
                // A real sample takes priority over flush.
                HAVE_A: if (in_fire) begin
                    b_q     <= bus.in_data;
                    odd_q   <= 1'b0;
                    state_q <= FULL;
                end else if (bus.flush) begin
                    b_q     <= a_q;
                    odd_q   <= 1'b1;
                    state_q <= FULL;
                end
                // A sample arriving with the hand-off starts the next pair.
                FULL: if (out_fire) begin
                    if (in_fire) a_q <= bus.in_data;
                    state_q <= in_fire ? HAVE_A : EMPTY;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_pair_collector.sv
// tb_sample_pair_collector: directed stimulus against a queue-based pairing model
module tb_sample_pair_collector;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sample_pair_if #(.DATA_W(8), .CNT_W(16)) b1();
    sample_pair_if #(.DATA_W(8), .CNT_W(2))  b2();

    sample_pair_collector #(.DATA_W(8), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b1));
    sample_pair_collector #(.DATA_W(8), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    assign b2.in_valid   = b1.in_valid;
    assign b2.in_data    = b1.in_data;
    assign b2.flush      = b1.flush;
    assign b2.pair_ready = b1.pair_ready;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       odd;
    } pair_t;

    logic [7:0]  samp[$];
    pair_t       pq[$];
    logic [15:0] mcnt;
    logic        in_ok;
    logic        started = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: samples wait in samp until two (or one plus flush) form a pair in pq.
    always @(posedge clk) begin
        if (!rst_n) begin
            samp.delete();
            pq.delete();
            mcnt = 0;
        end else begin
            in_ok = pq.size() == 0 || b1.pair_ready;
            if (pq.size() != 0 && b1.pair_ready) begin
                void'(pq.pop_front());
                mcnt = mcnt + 1;
            end
            if (b1.in_valid && in_ok) begin
                samp.push_back(b1.in_data);
                if (samp.size() == 2) begin
                    pq.push_back('{a: samp[0], b: samp[1], odd: 1'b0});
                    samp.delete();
                end
            end else if (b1.flush && samp.size() == 1 && pq.size() == 0) begin
                pq.push_back('{a: samp[0], b: samp[0], odd: 1'b1});
                samp.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_in_ready", {31'd0, b1.in_ready}, {31'd0, pq.size() == 0 || b1.pair_ready});
            chk("m_pair_valid", {31'd0, b1.pair_valid}, {31'd0, pq.size() != 0});
            chk("m_pair_count", {16'd0, b1.pair_count}, {16'd0, mcnt});
            chk("m_pair_count_w2", {30'd0, b2.pair_count}, {30'd0, mcnt[1:0]});
            chk("m_pair_valid_w2", {31'd0, b2.pair_valid}, {31'd0, pq.size() != 0});
            if (pq.size() != 0) begin
                chk("m_pair_a", {23'd0, b1.pair_a}, {24'd0, pq[0].a});
                chk("m_pair_b", {23'd0, b1.pair_b}, {24'd0, pq[0].b});
                chk("m_pair_odd", {31'd0, b1.pair_odd}, {31'd0, pq[0].odd});
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic pr);
        b1.in_valid   = v;
        b1.in_data    = d;
        b1.flush      = f;
        b1.pair_ready = pr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst_n = 1'b1;
        started = 1'b1;
        chk("rst_valid", {31'd0, b1.pair_valid}, 0);
        chk("rst_a", {23'd0, b1.pair_a}, 0);
        chk("rst_b", {23'd0, b1.pair_b}, 0);
        chk("rst_in_ready", {31'd0, b1.in_ready}, 1);
        chk("rst_count", {16'd0, b1.pair_count}, 0);
        // basic pair
        step(1, 10, 0, 1);
        step(1, 20, 0, 1);
        chk("t1_a", {23'd0, b1.pair_a}, 10);
        chk("t1_b", {23'd0, b1.pair_b}, 20);
        chk("t1_odd", {31'd0, b1.pair_odd}, 0);
        chk("t1_valid", {31'd0, b1.pair_valid}, 1);
        step(0, 0, 0, 1);
        chk("t1_valid_drop", {31'd0, b1.pair_valid}, 0);
        chk("t1_count", {16'd0, b1.pair_count}, 1);
        // full-scale samples keep MSB clear
        step(1, 255, 0, 1);
        step(1, 255, 0, 1);
        chk("t2_a", {23'd0, b1.pair_a}, 32'h0FF);
        chk("t2_b", {23'd0, b1.pair_b}, 32'h0FF);
        chk("t2_avg", (32'(b1.pair_a) + 32'(b1.pair_b) + 1) >> 1, 255);
        step(0, 0, 0, 1);
        // backpressure
        step(1, 3, 0, 0);
        step(1, 4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 9, 0, 0);
            chk("t3_in_ready", {31'd0, b1.in_ready}, 0);
            chk("t3_hold_a", {23'd0, b1.pair_a}, 3);
            chk("t3_hold_b", {23'd0, b1.pair_b}, 4);
        end
        step(1, 9, 0, 1);
        chk("t3_released", {31'd0, b1.pair_valid}, 0);
        chk("t3_count", {16'd0, b1.pair_count}, 3);
        step(1, 11, 0, 0);
        chk("t3_next_a", {23'd0, b1.pair_a}, 9);
        chk("t3_next_b", {23'd0, b1.pair_b}, 11);
        step(0, 0, 1, 1);
        // flush closes a lone sample
        step(1, 7, 0, 1);
        step(0, 0, 1, 0);
        chk("t4_a", {23'd0, b1.pair_a}, 7);
        chk("t4_b", {23'd0, b1.pair_b}, 7);
        chk("t4_odd", {31'd0, b1.pair_odd}, 1);
        step(0, 0, 1, 0);
        chk("t4_full_flush_hold", {31'd0, b1.pair_valid}, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("t4_empty_flush", {31'd0, b1.pair_valid}, 0);
        chk("t4_count", {16'd0, b1.pair_count}, 5);
        // real sample beats flush
        step(1, 5, 0, 1);
        step(1, 12, 1, 1);
        chk("t5_a", {23'd0, b1.pair_a}, 5);
        chk("t5_b", {23'd0, b1.pair_b}, 12);
        chk("t5_odd", {31'd0, b1.pair_odd}, 0);
        step(0, 0, 0, 1);
        chk("t5_count_w2", {30'd0, b2.pair_count}, 2);
        // reset while FULL
        step(1, 30, 0, 0);
        step(1, 40, 0, 0);
        rst_n = 1'b0;
        step(1, 50, 1, 1);
        rst_n = 1'b1;
        chk("t6_valid", {31'd0, b1.pair_valid}, 0);
        chk("t6_count", {16'd0, b1.pair_count}, 0);
        chk("t6_a", {23'd0, b1.pair_a}, 0);
        chk("t6_in_ready", {31'd0, b1.in_ready}, 1);
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        chk("t6_pair_a", {23'd0, b1.pair_a}, 1);
        chk("t6_pair_b", {23'd0, b1.pair_b}, 2);
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 8'(60 + i), 0, 1);
        step(0, 0, 0, 1);
        chk("t6_count5", {16'd0, b1.pair_count}, 5);
        chk("t6_count5_w2", {30'd0, b2.pair_count}, 1);
        step(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
